// File: rtl/arbiter_jednostki.sv
// Two-port round-robin arbiter/sequencer in front of a shared combinational
// arithmetic datapath. One transaction at a time: accept, issue, respond.
module arbiter_jednostki #(
    parameter int unsigned BITS = 32,
    parameter int unsigned OPW  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [OPW-1:0]  i_req0_op,
    input  logic [BITS-1:0] i_req0_arg_A,
    input  logic [BITS-1:0] i_req0_arg_B,
    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [OPW-1:0]  i_req1_op,
    input  logic [BITS-1:0] i_req1_arg_A,
    input  logic [BITS-1:0] i_req1_arg_B,
    output logic [OPW-1:0]  o_dp_op,
    output logic [BITS-1:0] o_dp_arg_A,
    output logic [BITS-1:0] o_dp_arg_B,
    input  logic [BITS-1:0] i_dp_result,
    input  logic            i_dp_error,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic            o_rsp_id,
    output logic [BITS-1:0] o_rsp_result,
    output logic            o_rsp_error,
    output logic            o_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_grant_q;
    logic            grant_q;
    logic            sel;
    logic            accept;
    logic [OPW-1:0]  dp_op_q;
    logic [BITS-1:0] dp_a_q, dp_b_q;
    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic [BITS-1:0] rsp_result_q;
    logic            rsp_error_q;

    // Pick a port: a lone valid wins outright, a tie goes to the port not served last.
    always_comb begin
        if (i_req0_valid && i_req1_valid) begin
            sel = ~last_grant_q;
        end else begin
            sel = i_req1_valid;
        end
        o_req0_ready = (state_q == IDLE) && i_req0_valid && !sel;
        o_req1_ready = (state_q == IDLE) && i_req1_valid && sel;
        accept       = o_req0_ready || o_req1_ready;
    end

    // Sequencer next state: IDLE -> ISSUE (one cycle) -> RESP until consumed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, arbitration history and the operand registers feeding the datapath.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            dp_op_q      <= '0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= sel;
                grant_q      <= sel;
                dp_op_q      <= sel ? i_req1_op    : i_req0_op;
                dp_a_q       <= sel ? i_req1_arg_A : i_req0_arg_A;
                dp_b_q       <= sel ? i_req1_arg_B : i_req0_arg_B;
            end
        end
    end

    // Response registers: capture the datapath at the end of ISSUE, hold until consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
        end else if (state_q == ISSUE) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant_q;
            rsp_result_q <= i_dp_result;
            rsp_error_q  <= i_dp_error;
        end else if (state_q == RESP && i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign o_dp_op      = dp_op_q;
    assign o_dp_arg_A   = dp_a_q;
    assign o_dp_arg_B   = dp_b_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_error  = rsp_error_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_arbiter_jednostki.sv
// Bench for arbiter_jednostki: table of transactions plus hand-written
// backpressure and reset corner cases, against a small datapath model.
module tb_arbiter_jednostki;

    localparam int unsigned BITS = 32;
    localparam int unsigned OPW  = 2;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_req0_valid, i_req1_valid;
    logic            o_req0_ready, o_req1_ready;
    logic [OPW-1:0]  i_req0_op, i_req1_op;
    logic [BITS-1:0] i_req0_arg_A, i_req0_arg_B, i_req1_arg_A, i_req1_arg_B;
    logic [OPW-1:0]  o_dp_op;
    logic [BITS-1:0] o_dp_arg_A, o_dp_arg_B;
    logic [BITS-1:0] i_dp_result;
    logic            i_dp_error;
    logic            o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_error, o_busy;
    logic [BITS-1:0] o_rsp_result;

    int n_cmp = 0;
    int n_err = 0;

    arbiter_jednostki #(.BITS(BITS), .OPW(OPW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_op    (i_req0_op),
        .i_req0_arg_A (i_req0_arg_A),
        .i_req0_arg_B (i_req0_arg_B),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_op    (i_req1_op),
        .i_req1_arg_A (i_req1_arg_A),
        .i_req1_arg_B (i_req1_arg_B),
        .o_dp_op      (o_dp_op),
        .o_dp_arg_A   (o_dp_arg_A),
        .o_dp_arg_B   (o_dp_arg_B),
        .i_dp_result  (i_dp_result),
        .i_dp_error   (i_dp_error),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_result (o_rsp_result),
        .o_rsp_error  (o_rsp_error),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Datapath model: 0 = arithmetic shift right, 1 = add, 2 = sub, 3 = xor.
    always_comb begin
        i_dp_error  = 1'b0;
        i_dp_result = '0;
        case (o_dp_op)
            2'd0: begin
                if ($signed(o_dp_arg_B) < 0 || o_dp_arg_B >= 32'd32) begin
                    i_dp_error  = 1'b1;
                    i_dp_result = 32'hDEAD_BEEF;
                end else begin
                    i_dp_result = $signed(o_dp_arg_A) >>> o_dp_arg_B[4:0];
                end
            end
            2'd1:    i_dp_result = o_dp_arg_A + o_dp_arg_B;
            2'd2:    i_dp_result = o_dp_arg_A - o_dp_arg_B;
            default: i_dp_result = o_dp_arg_A ^ o_dp_arg_B;
        endcase
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, wanted %b", nm, act, exp);
        end
    endtask

    typedef struct {
        logic           v0;
        logic           v1;
        logic [1:0]     op0;
        logic [31:0]    a0;
        logic [31:0]    b0;
        logic [1:0]     op1;
        logic [31:0]    a1;
        logic [31:0]    b1;
        logic           id;
        logic [31:0]    res;
        logic           err;
    } vec_t;

    vec_t vecs[8];
    vec_t post_rst;

    // Called ~1 time unit after a rising edge with the DUT idle; takes exactly 3 cycles.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ea;
        i_req0_valid = v.v0;
        i_req0_op    = v.op0;
        i_req0_arg_A = v.a0;
        i_req0_arg_B = v.b0;
        i_req1_valid = v.v1;
        i_req1_op    = v.op1;
        i_req1_arg_A = v.a1;
        i_req1_arg_B = v.b1;
        i_rsp_ready  = 1'b1;
        ea = v.id ? v.a1 : v.a0;
        #1;
        chk1($sformatf("v%0d ready0", idx), o_req0_ready, v.v0 && (v.id == 1'b0));
        chk1($sformatf("v%0d ready1", idx), o_req1_ready, v.v1 && (v.id == 1'b1));
        @(posedge i_clk); #1;
        chk1($sformatf("v%0d issue busy", idx), o_busy, 1'b1);
        chk1($sformatf("v%0d issue rsp_valid", idx), o_rsp_valid, 1'b0);
        chk1($sformatf("v%0d issue ready0", idx), o_req0_ready, 1'b0);
        chk1($sformatf("v%0d issue ready1", idx), o_req1_ready, 1'b0);
        chk32($sformatf("v%0d dp_A", idx), o_dp_arg_A, ea);
        @(posedge i_clk); #1;
        chk1($sformatf("v%0d rsp_valid", idx), o_rsp_valid, 1'b1);
        chk1($sformatf("v%0d rsp_id", idx), o_rsp_id, v.id);
        chk32($sformatf("v%0d rsp_result", idx), o_rsp_result, v.res);
        chk1($sformatf("v%0d rsp_error", idx), o_rsp_error, v.err);
        chk1($sformatf("v%0d resp ready1", idx), o_req1_ready, 1'b0);
        @(posedge i_clk); #1;
        chk1($sformatf("v%0d done rsp_valid", idx), o_rsp_valid, 1'b0);
        chk1($sformatf("v%0d done busy", idx), o_busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Round-robin run with both valids held, then single-port and error cases.
        vecs[0] = '{1, 1, 0, 32'hF0, 32'd4, 1, 32'd5, 32'd7, 0, 32'h0000_000F, 0};
        vecs[1] = '{1, 1, 3, 32'd1, 32'd1, 1, 32'd5, 32'd7, 1, 32'h0000_000C, 0};
        vecs[2] = '{1, 1, 2, 32'd3, 32'd10, 1, 32'd100, 32'd1, 0, 32'hFFFF_FFF9, 0};
        vecs[3] = '{1, 1, 0, 32'hF0, 32'd4, 3, 32'hFF00_FF00, 32'h0F0F_0F0F, 1,
                    32'hF00F_F00F, 0};
        vecs[4] = '{1, 0, 0, 32'hF0, 32'd4, 0, 32'd0, 32'd0, 0, 32'h0000_000F, 0};
        vecs[5] = '{0, 1, 0, 32'd0, 32'd0, 0, 32'h8000_0000, 32'd32, 1, 32'hDEAD_BEEF, 1};
        vecs[6] = '{0, 1, 0, 32'd0, 32'd0, 0, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, 0};
        vecs[7] = '{1, 1, 0, 32'd1, 32'hFFFF_FFFF, 1, 32'd2, 32'd2, 0, 32'hDEAD_BEEF, 1};
        post_rst = '{1, 1, 1, 32'h40, 32'd2, 1, 32'd9, 32'd9, 0, 32'h0000_0042, 0};

        i_rst = 1'b1;
        i_req0_valid = 0; i_req1_valid = 0;
        i_req0_op = '0; i_req1_op = '0;
        i_req0_arg_A = '0; i_req0_arg_B = '0; i_req1_arg_A = '0; i_req1_arg_B = '0;
        i_rsp_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk1("reset rsp_valid", o_rsp_valid, 1'b0);
        chk1("reset busy", o_busy, 1'b0);
        chk32("reset dp_A", o_dp_arg_A, 32'h0);
        chk32("reset dp_B", o_dp_arg_B, 32'h0);
        chk32("reset dp_op", 32'(o_dp_op), 32'h0);
        chk32("reset rsp_result", o_rsp_result, 32'h0);
        chk1("reset rsp_id", o_rsp_id, 1'b0);
        chk1("reset rsp_error", o_rsp_error, 1'b0);
        #3 i_rst = 1'b0;
        @(posedge i_clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Backpressure: response held for 5 cycles while port 1 waits.
        i_rsp_ready  = 1'b0;
        i_req1_valid = 1'b0;
        i_req0_valid = 1'b1; i_req0_op = 2'd1; i_req0_arg_A = 32'd1; i_req0_arg_B = 32'd2;
        #1 chk1("bp accept0", o_req0_ready, 1'b1);
        @(posedge i_clk); #1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b1; i_req1_op = 2'd1; i_req1_arg_A = 32'd10; i_req1_arg_B = 32'd20;
        @(posedge i_clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk1($sformatf("bp%0d rsp_valid", c), o_rsp_valid, 1'b1);
            chk32($sformatf("bp%0d rsp_result", c), o_rsp_result, 32'd3);
            chk1($sformatf("bp%0d rsp_id", c), o_rsp_id, 1'b0);
            chk1($sformatf("bp%0d ready1", c), o_req1_ready, 1'b0);
            @(posedge i_clk); #1;
        end
        i_rsp_ready = 1'b1;
        #1 chk1("bp pre-handshake ready1", o_req1_ready, 1'b0);
        @(posedge i_clk); #1;
        chk1("bp after rsp valid", o_rsp_valid, 1'b0);
        chk1("bp after ready1", o_req1_ready, 1'b1);
        @(posedge i_clk); #1;
        i_req1_valid = 1'b0;
        @(posedge i_clk); #1;
        chk1("bp p1 rsp_valid", o_rsp_valid, 1'b1);
        chk1("bp p1 rsp_id", o_rsp_id, 1'b1);
        chk32("bp p1 rsp_result", o_rsp_result, 32'h0000_001E);
        @(posedge i_clk); #1;

        // Reset asserted mid-cycle during ISSUE discards the transaction.
        i_req1_valid = 1'b1; i_req1_op = 2'd3; i_req1_arg_A = 32'hF; i_req1_arg_B = 32'h1;
        @(posedge i_clk); #1;
        i_req1_valid = 1'b0;
        chk1("midop busy before reset", o_busy, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        chk1("midop rst busy", o_busy, 1'b0);
        chk1("midop rst rsp_valid", o_rsp_valid, 1'b0);
        chk32("midop rst dp_A", o_dp_arg_A, 32'h0);
        chk32("midop rst dp_B", o_dp_arg_B, 32'h0);
        @(posedge i_clk); #4 i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk); #1;
            chk1($sformatf("midop quiet%0d rsp_valid", c), o_rsp_valid, 1'b0);
        end
        run_vec(post_rst, 8);

        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
